// File: rtl/winner_search.sv
// Winner search for a 4x4 self-organising map: scans 16 neuron distances and latches the index of the smallest one.
// Optional build macro WINNER_DIST_OUT_EN adds the min_dist output carrying the winning distance.
module winner_search #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          dist_valid,
    input  logic [DW-1:0] dist_in,
    output logic          busy,
    output logic          done,
    output logic [3:0]    coordinate_c,
    output logic          USS_ctrl
`ifdef WINNER_DIST_OUT_EN
    ,
    output logic [DW-1:0] min_dist
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [3:0]      cnt;
    logic [DW-1:0]   best_dist;
    logic [3:0]      best_idx;
    logic            init_search;
    logic            consume;
    logic            last_sample;
    logic            take;
    logic [DW-1:0]   cand_dist;
    logic [3:0]      cand_idx;

    // Strict less-than keeps the earliest neuron on ties; the first sample always seeds the search.
    function automatic logic is_better(input logic          first,
                                       input logic [DW-1:0] d,
                                       input logic [DW-1:0] b);
        return first || (d < b);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        init_search = 1'b0;
        consume     = 1'b0;
        last_sample = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = SCAN;
                    init_search = 1'b1;
                end
            end
            SCAN: begin
                if (start) begin
                    init_search = 1'b1;
                end else if (dist_valid) begin
                    consume = 1'b1;
                    if (cnt == 4'd15) begin
                        last_sample = 1'b1;
                        state_nxt   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (start) begin
                    state_nxt   = SCAN;
                    init_search = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Candidate winner including the sample consumed this cycle, so the final sample reaches coordinate_c.
    always_comb begin
        take      = consume && is_better(cnt == 4'd0, dist_in, best_dist);
        cand_dist = take ? dist_in : best_dist;
        cand_idx  = take ? cnt     : best_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= 4'd0;
            best_dist    <= '1;
            best_idx     <= 4'd0;
            coordinate_c <= 4'd0;
            done         <= 1'b0;
        end else begin
            done <= last_sample;
            if (init_search) begin
                cnt       <= 4'd0;
                best_dist <= '1;
                best_idx  <= 4'd0;
            end else if (consume) begin
                cnt       <= last_sample ? cnt : cnt + 4'd1;
                best_dist <= cand_dist;
                best_idx  <= cand_idx;
            end
            if (last_sample) begin
                coordinate_c <= cand_idx;
            end
        end
    end

`ifdef WINNER_DIST_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            min_dist <= '0;
        end else if (last_sample) begin
            min_dist <= cand_dist;
        end
    end
`endif

    assign busy     = (state == SCAN);
    assign USS_ctrl = (state != HOLD);

endmodule

// File: tb/tb_winner_search.sv
// Scoreboard bench for winner_search: each search pushes its hand-computed winner, a monitor pops it on done.
module tb_winner_search;

    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          dist_valid;
    logic [DW-1:0] dist_in;
    logic          busy;
    logic          done;
    logic [3:0]    coordinate_c;
    logic          USS_ctrl;
`ifdef WINNER_DIST_OUT_EN
    logic [DW-1:0] min_dist;
`endif

    winner_search #(.DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .dist_valid   (dist_valid),
        .dist_in      (dist_in),
        .busy         (busy),
        .done         (done),
        .coordinate_c (coordinate_c),
        .USS_ctrl     (USS_ctrl)
`ifdef WINNER_DIST_OUT_EN
        ,
        .min_dist     (min_dist)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]    c;
        logic [DW-1:0] d;
    } exp_t;

    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] vec[16];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [DW-1:0] d);
        start      = s;
        dist_valid = v;
        dist_in    = d;
        @(posedge clk);
        #1;
    endtask

    // Feeds vec[0..15]; optional start pulse and optional random idle gaps between samples.
    task automatic run_search(input bit do_start, input bit gaps);
        if (do_start) begin
            cyc(1'b1, 1'b0, '0);
            chk("busy_after_start", int'(busy), 1);
            chk("done_after_start", int'(done), 0);
        end
        for (int i = 0; i < 16; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    cyc(1'b0, 1'b0, '0);
                    chk("busy_in_gap", int'(busy), 1);
                end
            end
            cyc(1'b0, 1'b1, vec[i]);
            if (i < 15) begin
                chk("busy_scan", int'(busy), 1);
                chk("done_early", int'(done), 0);
            end else begin
                chk("busy_hold", int'(busy), 0);
                chk("done_pulse", int'(done), 1);
                chk("uss_hold", int'(USS_ctrl), 0);
            end
        end
        cyc(1'b0, 1'b0, '0);
        chk("done_single", int'(done), 0);
        chk("uss_hold_2", int'(USS_ctrl), 0);
    endtask

    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending search at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("coordinate_c", int'(coordinate_c), int'(e.c));
                chk("uss_on_done", int'(USS_ctrl), 0);
`ifdef WINNER_DIST_OUT_EN
                chk("min_dist", int'(min_dist), int'(e.d));
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        dist_valid = 1'b0;
        dist_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_coord", int'(coordinate_c), 0);
        chk("rst_uss", int'(USS_ctrl), 1);
`ifdef WINNER_DIST_OUT_EN
        chk("rst_min_dist", int'(min_dist), 0);
`endif
        rst = 1'b0;
        cyc(1'b0, 1'b1, '0);
        chk("idle_ignores_valid", int'(busy), 0);

        // Single minimum at n=9.
        for (int i = 0; i < 16; i++) vec[i] = 12'd100;
        vec[9] = 12'd5;
        exp_q.push_back('{c: 4'd9, d: 12'd5});
        run_search(1'b1, 1'b0);
        repeat (3) cyc(1'b0, 1'b1, '0);
        chk("hold_coord", int'(coordinate_c), 9);
        chk("hold_uss", int'(USS_ctrl), 0);
        chk("hold_busy", int'(busy), 0);

        // All samples at the maximum value.
        for (int i = 0; i < 16; i++) vec[i] = 12'hFFF;
        exp_q.push_back('{c: 4'd0, d: 12'hFFF});
        run_search(1'b1, 1'b0);

        // Ties at n=3 and n=12.
        for (int i = 0; i < 16; i++) vec[i] = 12'd20;
        vec[3]  = 12'd7;
        vec[12] = 12'd7;
        exp_q.push_back('{c: 4'd3, d: 12'd7});
        run_search(1'b1, 1'b0);

        // Strictly decreasing with gaps, minimum at n=15.
        for (int i = 0; i < 16; i++) vec[i] = 12'(200 - i * 10);
        exp_q.push_back('{c: 4'd15, d: 12'd50});
        run_search(1'b1, 1'b1);

        // Reset after 8 samples, reset also overriding start and dist_valid.
        cyc(1'b1, 1'b0, '0);
        chk("coord_held_in_scan", int'(coordinate_c), 15);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, (i == 5) ? 12'd1 : 12'd30);
        rst = 1'b1;
        cyc(1'b1, 1'b1, '0);
        rst = 1'b0;
        chk("midscan_rst_busy", int'(busy), 0);
        chk("midscan_rst_coord", int'(coordinate_c), 0);
        chk("midscan_rst_uss", int'(USS_ctrl), 1);
        for (int i = 0; i < 16; i++) vec[i] = 12'd30;
        vec[2] = 12'd4;
        exp_q.push_back('{c: 4'd2, d: 12'd4});
        run_search(1'b1, 1'b0);

        // Restart after 5 samples; the restart-cycle sample must be discarded.
        cyc(1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, '0);
        cyc(1'b1, 1'b1, '0);
        chk("restart_busy", int'(busy), 1);
        chk("coord_held_restart", int'(coordinate_c), 2);
        for (int i = 0; i < 16; i++) vec[i] = 12'd50;
        vec[6] = 12'd10;
        exp_q.push_back('{c: 4'd6, d: 12'd10});
        run_search(1'b0, 1'b0);

        repeat (3) cyc(1'b0, 1'b0, '0);
        chk("all_searches_done", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
